// File: rtl/alu_ops_pkg.sv
// ============================================================================
// Module      : alu_ops_pkg
// Description : ALU operation codes and multiply-sequencer state encoding,
//               shared by the ALU control decoder, the ALU and the MUL
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ops_pkg;

    // ALU operation codes as produced by the ALU control decoder
    localparam logic [5:0] c_alu_add = 6'b100000;
    localparam logic [5:0] c_alu_sub = 6'b100010;
    localparam logic [5:0] c_alu_mul = 6'b011000;
    localparam logic [5:0] c_alu_and = 6'b100100;
    localparam logic [5:0] c_alu_or  = 6'b100101;
    localparam logic [5:0] c_alu_nor = 6'b100111;
    localparam logic [5:0] c_alu_xor = 6'b100110;
    localparam logic [5:0] c_alu_sll = 6'b000000;
    localparam logic [5:0] c_alu_srl = 6'b000010;
    localparam logic [5:0] c_alu_slt = 6'b101010;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

endpackage : alu_ops_pkg

`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
// ============================================================================
// Module      : mul_shift_add_dp
// Description : Shift-add multiply datapath. Works on operand magnitudes and
//               applies the product sign once at the end. Driven by load,
//               step and fix strobes from the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_fix,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_sign;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_acc_neg;

    // Magnitudes; the most negative value wraps to itself and is then read
    // as the unsigned value 2^(WIDTH-1), which still yields correct low bits.
    assign w_abs_a   = i_a[WIDTH-1] ? (~i_a + c_one) : i_a;
    assign w_abs_b   = i_b[WIDTH-1] ? (~i_b + c_one) : i_b;
    assign w_acc_neg = ~r_acc + c_one;

    // Operand load, one shift-add iteration per step, sign fix-up into Result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= w_abs_a;
                r_mplier <= w_abs_b;
                r_sign   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                r_acc    <= '0;
            end else if (i_step) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            if (i_fix) begin
                r_result <= r_sign ? w_acc_neg : r_acc;
            end
        end
    end

    assign o_result = r_result;

endmodule : mul_shift_add_dp

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module      : alu_mul_sequencer
// Description : EX-stage controller for the multi-cycle MUL operation. Stalls
//               the pipeline while a WIDTH-iteration shift-add multiply runs
//               and strobes Done for one cycle when Result is valid. Other
//               ALU operations pass through without stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer
    import alu_ops_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] MUL_CODE = c_alu_mul
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    mul_state_t         r_state;
    mul_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_count;

    logic w_accept;
    logic w_load;
    logic w_step;
    logic w_fix;

    assign w_accept = Start && (ALUControl == MUL_CODE) && !Flush;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Iteration counter, cleared on accept, advanced once per RUN step
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Next state, datapath strobes and pipeline handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        Stall        = 1'b0;
        Done         = 1'b0;
        Busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // Stall is raised in the accept cycle itself so ID/EX holds the MUL
                if (w_accept) begin
                    w_load       = 1'b1;
                    Stall        = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                Stall = 1'b1;
                if (Flush) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_count == c_LAST) begin
                        w_state_next = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                Stall = 1'b1;
                if (Flush) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_fix        = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // ID/EX still holds the finished MUL, so Start is not looked at here
                Done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (Clk),
        .rst      (Rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_a      (A),
        .i_b      (B),
        .o_result (Result)
    );

endmodule : alu_mul_sequencer

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Self-checking bench for alu_mul_sequencer with a plain
//               arithmetic reference model for the product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;
    import alu_ops_pkg::*;

    localparam int c_W   = 32;
    localparam int c_LAT = c_W + 2;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Start;
    logic [5:0]     ALUControl;
    logic [c_W-1:0] A;
    logic [c_W-1:0] B;
    logic           Flush;
    logic           Stall;
    logic           Busy;
    logic           Done;
    logic [c_W-1:0] Result;

    int n_pass  = 0;
    int n_total = 0;
    logic [c_W-1:0] last_result = '0;

    alu_mul_sequencer #(.WIDTH(c_W), .MUL_CODE(c_alu_mul)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .Flush      (Flush),
        .Stall      (Stall),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result)
    );

    always #5 Clk = ~Clk;

    // Reference: low bits of the true signed product
    function automatic logic [c_W-1:0] ref_mul(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return p[c_W-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #2;
    endtask

    // Drives one MUL from its accept cycle up to its Done cycle and checks it.
    // Returns with the bench sitting in the Done cycle, Start still high.
    task automatic run_mul(input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        int lat;
        int stall_cnt;
        bit seen;
        logic [c_W-1:0] exp;
        exp = ref_mul(a, b);
        Start = 1'b1; ALUControl = c_alu_mul; A = a; B = b; Flush = 1'b0;
        #1;
        n_total++;
        if (Stall !== 1'b1) $display("FAIL accept_stall: got %b want 1", Stall);
        else n_pass++;
        lat = 0; stall_cnt = 0; seen = 1'b0;
        while (!seen && lat <= 100) begin
            if (Done === 1'b1) seen = 1'b1;
            else begin
                if (Stall === 1'b1) stall_cnt++;
                next_cycle();
                lat++;
            end
        end
        n_total++;
        if (!seen || lat != c_LAT) $display("FAIL done_latency a=%h b=%h: got %0d want %0d", a, b, lat, c_LAT);
        else n_pass++;
        n_total++;
        if (stall_cnt != c_LAT) $display("FAIL stall_cycles: got %0d want %0d", stall_cnt, c_LAT);
        else n_pass++;
        n_total++;
        if (Result !== exp) $display("FAIL result a=%h b=%h: got %h want %h", a, b, Result, exp);
        else n_pass++;
        n_total++;
        if (Stall !== 1'b0 || Busy !== 1'b1) $display("FAIL done_cycle_flags: got stall=%b busy=%b want 0 1", Stall, Busy);
        else n_pass++;
        last_result = exp;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; ALUControl = c_alu_add; A = '0; B = '0; Flush = 1'b0;
        next_cycle();
        next_cycle();
        Rst = 1'b0;
        #1;
        n_total++;
        if ({Stall, Busy, Done} !== 3'b000 || Result !== '0)
            $display("FAIL reset_state: got stall=%b busy=%b done=%b result=%h want 0", Stall, Busy, Done, Result);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6);
        next_cycle();
        Start = 1'b0;
        #1;
        n_total++;
        if ({Stall, Busy, Done} !== 3'b000 || Result !== 32'd42)
            $display("FAIL after_done: got stall=%b busy=%b done=%b result=%h want 000 42", Stall, Busy, Done, Result);
        else n_pass++;
    endtask

    task automatic test_signed();
        logic [c_W-1:0] ta [3];
        logic [c_W-1:0] tb [3];
        ta[0] = -32'sd3;       tb[0] = 32'd5;
        ta[1] = -32'sd4;       tb[1] = -32'sd8;
        ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            run_mul(ta[i], tb[i]);
            next_cycle();
            Start = 1'b0;
        end
    endtask

    task automatic test_passthrough();
        Start = 1'b1; ALUControl = c_alu_add; A = 32'd11; B = 32'd22; Flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_total++;
            if ({Stall, Busy, Done} !== 3'b000)
                $display("FAIL passthrough_add: got stall=%b busy=%b done=%b want 000", Stall, Busy, Done);
            else n_pass++;
            next_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 63));
            if (op == c_alu_mul) op = c_alu_sub;
            ALUControl = op; A = $urandom; B = $urandom;
            #1;
            n_total++;
            if ({Stall, Busy, Done} !== 3'b000)
                $display("FAIL passthrough_op%h: got stall=%b busy=%b done=%b want 000", op, Stall, Busy, Done);
            else n_pass++;
            next_cycle();
        end
        // A flushed MUL is never accepted
        ALUControl = c_alu_mul; Flush = 1'b1;
        #1;
        n_total++;
        if (Stall !== 1'b0) $display("FAIL flush_on_accept_stall: got %b want 0", Stall);
        else n_pass++;
        next_cycle();
        n_total++;
        if (Busy !== 1'b0) $display("FAIL flush_on_accept_busy: got %b want 0", Busy);
        else n_pass++;
        Start = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_flush();
        bit done_seen;
        Start = 1'b1; ALUControl = c_alu_mul; A = 32'd123; B = 32'd456; Flush = 1'b0;
        next_cycle();
        repeat (9) next_cycle();
        Flush = 1'b1;
        #1;
        n_total++;
        if (Busy !== 1'b1 || Stall !== 1'b1) $display("FAIL flush_cycle: got busy=%b stall=%b want 1 1", Busy, Stall);
        else n_pass++;
        next_cycle();
        Flush = 1'b0; Start = 1'b0;
        #1;
        n_total++;
        if (Busy !== 1'b0 || Stall !== 1'b0) $display("FAIL flush_idle: got busy=%b stall=%b want 0 0", Busy, Stall);
        else n_pass++;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) done_seen = 1'b1;
            next_cycle();
        end
        n_total++;
        if (done_seen) $display("FAIL flush_no_done: got done=1 want 0");
        else n_pass++;
        n_total++;
        if (Result !== last_result) $display("FAIL flush_result_hold: got %h want %h", Result, last_result);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int v = 0; v < 2; v++) begin
            Start = 1'b1; ALUControl = c_alu_mul; A = 32'd1000; B = 32'd3; Flush = 1'b0;
            next_cycle();
            repeat (19) next_cycle();
            Rst = 1'b1; Flush = (v == 1);
            next_cycle();
            Rst = 1'b0; Flush = 1'b0; Start = 1'b0;
            #1;
            n_total++;
            if ({Stall, Busy, Done} !== 3'b000 || Result !== '0)
                $display("FAIL reset_mid_v%0d: got stall=%b busy=%b done=%b result=%h want 0", v, Stall, Busy, Done, Result);
            else n_pass++;
            last_result = '0;
            run_mul(32'd9, -32'sd9);
            next_cycle();
            Start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        run_mul(32'd3, 32'd5);
        next_cycle();
        run_mul(32'h0001_0000, 32'h0001_0000);
        next_cycle();
        Start = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [c_W-1:0] a;
            logic [c_W-1:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = 32'($urandom_range(0, 1000)) - 32'd500;
            if (i % 4 == 2) b = 32'($urandom_range(0, 1000)) - 32'd500;
            run_mul(a, b);
            next_cycle();
            Start = 1'b0;
            if (i % 2 == 1) next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_passthrough();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_mul_sequencer

`default_nettype wire
